i2c_slave_responder: RTL and testbench

//  I2C target (responder) answering the i2c master block on the shared open-drain bus.

---
 rtl/i2c_slv_pkg.sv | 26 ++
 rtl/i2c_slv_line_filter.sv | 78 +++++++
 rtl/i2c_slave_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C target responder.
//   state_e       : responder FSM states
//   I2C_RW_*      : value of the R/W bit in the address byte
//   ACK / NACK    : SDA level of the 9th bit
package i2c_slv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        WR_BYTE,
        ACK_WR,
        RD_BYTE,
        ACK_RD,
        WAIT_STOP
    } state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_slv_line_filter.sv
// Input conditioning for one open-drain bus line (SCL or SDA).
// The line is synchronised, optionally majority-filtered, and converted
// into a clean level plus one-cycle rise/fall event pulses.
//
// Optional feature macro: I2C_SLV_GLITCH_FILTER_EN
//   defined   : 3-sample majority vote after the synchroniser; rejects
//               1-cycle pulses and adds one cycle of latency.
//   undefined : synchroniser output is used directly.
//
// Ports
//   i_clk    in   core clock
//   i_rst    in   synchronous reset, active-high (line reads as idle-high)
//   i_line   in   raw pad level
//   o_level  out  conditioned level
//   o_rise   out  1-cycle pulse on a 0->1 change of o_level
//   o_fall   out  1-cycle pulse on a 1->0 change of o_level
module i2c_slv_line_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync_out;
    logic                   w_level;

    // Reset to 1: an idle I2C bus is pulled high, so no edge fires on release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    // Vote over the current sample and the two before it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 2'b11;
            r_filt <= 1'b1;
        end else begin
            r_hist <= {r_hist[0], w_sync_out};
            r_filt <= (w_sync_out & r_hist[0]) |
                      (w_sync_out & r_hist[1]) |
                      (r_hist[0]  & r_hist[1]);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_sync_out;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target (responder) with a byte-wide register file.
// Matches a 7-bit address, ACKs it, accepts writes (first data byte sets
// the pointer, later bytes are stored with auto-increment) and serves
// reads from the pointer with auto-increment. No clock stretching.
//
// Optional feature macro: I2C_SLV_GLITCH_FILTER_EN (majority filter on
// SCL/SDA inside i2c_slv_line_filter).
//
// Ports
//   i2c_core_clock  in   core clock, >= 10x SCL rate
//   preset          in   synchronous reset, active-high
//   slave_addr_i    in   own 7-bit address
//   scl_i / sda_i   in   bus levels read back from the pads
//   sda_oe_o        out  1 = pull SDA low
//   busy_o          out  high from address match until STOP
//   start_o/stop_o  out  1-cycle pulses on (repeated) START / STOP
//   wr_stb_o        out  1-cycle pulse when a byte is stored
//   wr_idx_o        out  register index written
//   wr_data_o       out  byte written
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus free or not addressed since last STOP
// ADDR      | shifting in the address byte
// ACK_ADDR  | driving address ACK during the 9th clock
// WR_BYTE   | shifting in a write data byte
// ACK_WR    | driving data ACK during the 9th clock
// RD_BYTE   | driving a read data byte, MSB first
// ACK_RD    | SDA released, waiting for the master's ACK/NACK
// WAIT_STOP | released; not addressed or master NACKed
module i2c_slave_responder #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i2c_core_clock,
    input  logic              preset,
    input  logic [6:0]        slave_addr_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe_o,
    output logic              busy_o,
    output logic              start_o,
    output logic              stop_o,
    output logic              wr_stb_o,
    output logic [ADDR_W-1:0] wr_idx_o,
    output logic [7:0]        wr_data_o
);

    import i2c_slv_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start_evt, w_stop_evt;

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              r_first, w_first_nxt;
    logic              r_sda_oe, w_sda_oe_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_start, r_stop, r_wr_stb;
    logic [ADDR_W-1:0] r_wr_idx;
    logic [7:0]        r_wr_data;
    logic              w_mem_we;
    logic [7:0]        w_rd_byte;
    logic [7:0]        r_mem [DEPTH];

    i2c_slv_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_scl_filt (
        .i_clk   (i2c_core_clock),
        .i_rst   (preset),
        .i_line  (scl_i),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_slv_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sda_filt (
        .i_clk   (i2c_core_clock),
        .i_rst   (preset),
        .i_line  (sda_i),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    // Both lines share the same pipeline depth, so SCL level is aligned with
    // the SDA edge it qualifies.
    assign w_start_evt = w_sda_fall & w_scl;
    assign w_stop_evt  = w_sda_rise & w_scl;

    assign w_rd_byte = r_mem[r_ptr];

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_first_nxt   = r_first;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_mem_we      = 1'b0;

        // Bus conditions take priority over any coincident SCL edge.
        if (w_start_evt) begin
            w_state_nxt   = ADDR;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
        end else if (w_stop_evt) begin
            w_state_nxt  = IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == BITS_PER_BYTE) begin
                        if (r_shift[7:1] == slave_addr_i) begin
                            w_state_nxt  = ACK_ADDR;
                            w_sda_oe_nxt = 1'b1;
                            w_busy_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = WAIT_STOP;
                        end
                    end
                end
                ACK_ADDR: begin
                    // r_shift still holds the address byte; bit 0 is R/W.
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = '0;
                        if (r_shift[0] == I2C_RW_READ) begin
                            w_state_nxt  = RD_BYTE;
                            w_shift_nxt  = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                        end else begin
                            w_state_nxt  = WR_BYTE;
                            w_sda_oe_nxt = 1'b0;
                            w_first_nxt  = 1'b1;
                        end
                    end
                end
                WR_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == BITS_PER_BYTE) begin
                        w_state_nxt  = ACK_WR;
                        w_sda_oe_nxt = 1'b1;
                        if (r_first) begin
                            w_ptr_nxt   = r_shift[ADDR_W-1:0];
                            w_first_nxt = 1'b0;
                        end else begin
                            w_mem_we  = 1'b1;
                            w_ptr_nxt = r_ptr + 1'b1;
                        end
                    end
                end
                ACK_WR: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = WR_BYTE;
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = '0;
                    end
                end
                RD_BYTE: begin
                    // Shift on rise, present the new MSB on the following fall.
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == BITS_PER_BYTE) begin
                            w_state_nxt  = ACK_RD;
                            w_sda_oe_nxt = 1'b0;
                            w_ptr_nxt    = r_ptr + 1'b1;
                        end else begin
                            w_sda_oe_nxt = ~r_shift[7];
                        end
                    end
                end
                ACK_RD: begin
                    // On ACK the next byte is loaded now; its MSB goes out on
                    // the 9th fall through the RD_BYTE fall path (count 0).
                    if (w_scl_rise) begin
                        if (w_sda == ACK) begin
                            w_state_nxt   = RD_BYTE;
                            w_shift_nxt   = w_rd_byte;
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = WAIT_STOP;
                        end
                    end
                end
                IDLE, WAIT_STOP: begin
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i2c_core_clock) begin
        if (preset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_first   <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_first   <= w_first_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_start   <= w_start_evt;
            r_stop    <= w_stop_evt;
            r_wr_stb  <= w_mem_we;
            if (w_mem_we) begin
                r_wr_idx  <= r_ptr;
                r_wr_data <= r_shift;
            end
        end
    end

    always_ff @(posedge i2c_core_clock) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= r_shift;
        end
    end

    assign sda_oe_o  = r_sda_oe;
    assign busy_o    = r_busy;
    assign start_o   = r_start;
    assign stop_o    = r_stop;
    assign wr_stb_o  = r_wr_stb;
    assign wr_idx_o  = r_wr_idx;
    assign wr_data_o = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_responder.sv
module tb_i2c_slave_responder;

    localparam int ADDR_W = 4;
    localparam int Q      = 8;   // core clocks per quarter SCL period

    localparam logic [1:0] EV_START = 2'd0;
    localparam logic [1:0] EV_STOP  = 2'd1;
    localparam logic [1:0] EV_WR    = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic              clk = 1'b0;
    logic              preset;
    logic [6:0]        slave_addr;
    logic              scl_i, sda_i;
    logic              sda_oe, busy_o, start_o, stop_o, wr_stb_o;
    logic [ADDR_W-1:0] wr_idx;
    logic [7:0]        wr_data;

    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic m_override = 1'b0;   // lets the master force SDA high over the DUT's drive

    ev_t        exp_q[$];
    logic [7:0] exp_bus_q[$];
    logic [7:0] obs_bus_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    bit oe_seen = 1'b0;
    int n_start_seen = 0;
    int n_stop_seen  = 0;

    always #5 clk = ~clk;

    assign scl_i = m_scl;
    assign sda_i = m_sda & (m_override | ~sda_oe);

    i2c_slave_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .i2c_core_clock (clk),
        .preset         (preset),
        .slave_addr_i   (slave_addr),
        .scl_i          (scl_i),
        .sda_i          (sda_i),
        .sda_oe_o       (sda_oe),
        .busy_o         (busy_o),
        .start_o        (start_o),
        .stop_o         (stop_o),
        .wr_stb_o       (wr_stb_o),
        .wr_idx_o       (wr_idx),
        .wr_data_o      (wr_data)
    );

    // ---------------- monitor / scoreboard ----------------
    task automatic check_ev(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected: got kind=%0d a=%h b=%h, required no event", k, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.a !== a || e.b !== b) begin
                n_fail++;
                $display("FAIL event: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                         k, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] obs, expv;
        if (mon_en) begin
            if (sda_oe) oe_seen = 1'b1;
            if (start_o) begin
                n_start_seen++;
                check_ev(EV_START, 8'h00, 8'h00);
            end
            if (stop_o) begin
                n_stop_seen++;
                check_ev(EV_STOP, 8'h00, {6'b0, busy_o, sda_oe});
            end
            if (wr_stb_o) check_ev(EV_WR, {4'b0, wr_idx}, wr_data);
            while (obs_bus_q.size() > 0) begin
                obs = obs_bus_q.pop_front();
                n_cmp++;
                if (exp_bus_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_unexpected: got %h, required nothing", obs);
                end else begin
                    expv = exp_bus_q.pop_front();
                    if (obs !== expv) begin
                        n_fail++;
                        $display("FAIL bus_value: got %h, required %h", obs, expv);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, expv);
        end
    endtask

    task automatic exp_start();
        exp_q.push_back('{kind: EV_START, a: 8'h00, b: 8'h00});
    endtask

    task automatic exp_stop();
        exp_q.push_back('{kind: EV_STOP, a: 8'h00, b: 8'h00});
    endtask

    task automatic exp_wr(input logic [7:0] idx, input logic [7:0] d);
        exp_q.push_back('{kind: EV_WR, a: idx, b: d});
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        b = sda_i;    wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_bus_q.push_back({7'b0, exp_ack});
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        obs_bus_q.push_back({7'b0, a});
    endtask

    task automatic rd_byte(input logic [7:0] exp_d, input logic ack);
        logic [7:0] d;
        logic b;
        exp_bus_q.push_back(exp_d);
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        obs_bus_q.push_back(d);
        put_bit(ack);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic b;
        int   s0, p0;
        preset     = 1'b1;
        slave_addr = 7'h2A;
        repeat (5) @(negedge clk);
        preset = 1'b0;

        // 1: reset / idle bus
        check("reset_sda_oe", sda_oe, 0);
        check("reset_busy", busy_o, 0);
        check("reset_pulses", {start_o, stop_o, wr_stb_o}, 0);
        mon_en = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_sda_oe", sda_oe, 0);

        // 2: write 0x03, 0xA5, 0x5A to 0x2A
        exp_start(); bus_start();
        wr_byte(8'h54, 1'b0);
        check("busy_after_match", busy_o, 1);
        wr_byte(8'h03, 1'b0);
        exp_wr(8'd3, 8'hA5); wr_byte(8'hA5, 1'b0);
        exp_wr(8'd4, 8'h5A); wr_byte(8'h5A, 1'b0);
        exp_stop(); bus_stop();
        wait_q();
        check("busy_after_stop", busy_o, 0);

        // 3: set ptr 3, repeated START, read two bytes (ACK, NACK)
        exp_start(); bus_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h03, 1'b0);
        exp_start(); bus_start();
        wr_byte(8'h55, 1'b0);
        rd_byte(8'hA5, 1'b0);
        rd_byte(8'h5A, 1'b1);
        wait_q();
        check("wait_stop_released", sda_oe, 0);
        check("wait_stop_busy", busy_o, 1);
        exp_stop(); bus_stop();
        wait_q();

        // 4: foreign address 0x2B
        oe_seen = 1'b0;
        exp_start(); bus_start();
        wr_byte(8'h56, 1'b1);
        wr_byte(8'h00, 1'b1);
        wr_byte(8'h77, 1'b1);
        check("foreign_busy", busy_o, 0);
        exp_stop(); bus_stop();
        wait_q();
        check("foreign_never_drove", oe_seen, 0);

        // 5: pointer wrap on write and on read; upper pointer bits ignored
        exp_start(); bus_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h0F, 1'b0);
        exp_wr(8'd15, 8'h11); wr_byte(8'h11, 1'b0);
        exp_wr(8'd0,  8'h22); wr_byte(8'h22, 1'b0);
        exp_stop(); bus_stop();
        exp_start(); bus_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'hEF, 1'b0);
        exp_start(); bus_start();
        wr_byte(8'h55, 1'b0);
        rd_byte(8'h11, 1'b0);
        rd_byte(8'h22, 1'b1);
        exp_stop(); bus_stop();
        wait_q();

        // 6: STOP forced while the DUT pulls SDA low mid read byte (0xA5, bit6=0)
        exp_start(); bus_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h03, 1'b0);
        exp_start(); bus_start();
        wr_byte(8'h55, 1'b0);
        get_bit(b);
        exp_bus_q.push_back(8'h01);
        obs_bus_q.push_back({7'b0, b});
        check("mid_read_driving", sda_oe, 1);
        check("mid_read_busy", busy_o, 1);
        exp_stop();
        m_override = 1'b1;
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
        check("forced_stop_released", sda_oe, 0);
        check("forced_stop_busy", busy_o, 0);
        m_override = 1'b0;
        wait_q();

`ifdef I2C_SLV_GLITCH_FILTER_EN
        // 1-cycle SDA glitch with SCL high must not look like START/STOP
        s0 = n_start_seen;
        p0 = n_stop_seen;
        repeat (10) @(negedge clk);
        m_sda = 1'b0;
        @(negedge clk);
        m_sda = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_start", n_start_seen - s0, 0);
        check("glitch_no_stop", n_stop_seen - p0, 0);
`else
        s0 = 0;
        p0 = 0;
`endif

        repeat (50) @(negedge clk);
        check("events_drained", exp_q.size(), 0);
        check("bus_drained", exp_bus_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
